// File: rtl/load_store_unit.sv
// Data-side memory initiator: one load/store at a time, opcode/alignment check,
// WAIT_CYCLES-long memory access, response held until the consumer accepts it.
module load_store_unit #(
  parameter int WAIT_CYCLES = 1,
  parameter int CHECK_ALIGN = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic        mem_addrsrc,
  output logic [2:0]  mem_op,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        busy
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic w_bad_op, w_misalign, w_req_err, w_accept, w_last;

  always_comb begin
    w_bad_op   = (req_op == 3'b000) || (req_op == 3'b110) || (req_op == 3'b111);
    w_misalign = 1'b0;
    if (CHECK_ALIGN != 0) begin
      if ((req_op == 3'b010 || req_op == 3'b101) && req_addr[0]) w_misalign = 1'b1;
      if ((req_op == 3'b011) && (req_addr[1:0] != 2'b00))        w_misalign = 1'b1;
    end
    w_req_err = w_bad_op | w_misalign;
    w_accept  = (r_state == IDLE) && req_valid;
    w_last    = (r_state == ACCESS) && (r_cnt == 4'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    busy        = 1'b0;
    resp_valid  = 1'b0;
    mem_we      = 1'b0;
    mem_addrsrc = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = w_req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        busy        = 1'b1;
        mem_addrsrc = 1'b1;
        // Write strobe only on the final wait cycle so memory sees exactly one write.
        if (w_last) begin
          mem_we      = r_we;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        if (resp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Rejected requests never load the port registers, so the memory port keeps its last values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_op    <= 3'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_rdata <= 32'd0;
      r_err   <= w_req_err;
      if (!w_req_err) begin
        r_we    <= req_we;
        r_op    <= req_op;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= CNT_INIT;
      end
    end else if (r_state == ACCESS) begin
      if (!w_last)    r_cnt   <= r_cnt - 4'd1;
      else if (!r_we) r_rdata <= mem_rd;
    end
  end

  assign mem_op     = r_op;
  assign mem_addr   = r_addr;
  assign mem_wd     = r_wdata;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule
